// File: rtl/tmds_encoder_if.sv
// tmds_encoder_if: pixel-in / symbol-out bundle for one TMDS channel encoder
//   de_i    1      data enable (1 = active video, 0 = blanking/control)
//   data_i  8      pixel component, used when de_i=1
//   ctrl_i  2      control code {c1,c0}, used when de_i=0
//   tmds_o  10     encoded symbol, bit 0 transmitted first
//   disp_o  CNT_W  signed running disparity (debug)
interface tmds_encoder_if #(parameter int CNT_W = 5);
  logic                    de_i;
  logic [7:0]              data_i;
  logic [1:0]              ctrl_i;
  logic [9:0]              tmds_o;
  logic signed [CNT_W-1:0] disp_o;
  modport master (output de_i, data_i, ctrl_i, input tmds_o, disp_o);
  modport slave (input de_i, data_i, ctrl_i, output tmds_o, disp_o);
endinterface

// File: rtl/tmds_encoder.sv
// tmds_encoder: two-stage DVI TMDS 8b/10b encoder (transition minimisation, then DC balance)
//   clk_i   pixel clock
//   rst_ni  synchronous active-low reset
//   bus     tmds_encoder_if slave: de_i/data_i/ctrl_i in, tmds_o/disp_o out
module tmds_encoder #(parameter int CNT_W = 5) (
  input  logic         clk_i,
  input  logic         rst_ni,
  tmds_encoder_if.slave bus
);
  logic [3:0]              w_n1d, w_n1;
  logic                    w_xnor;
  logic [8:0]              w_qm;
  logic [8:0]              r_qm;
  logic                    r_de;
  logic [1:0]              r_ctrl;
  logic [9:0]              w_tmds, w_ctl, r_tmds;
  logic signed [CNT_W-1:0] w_d, w_cnt_nx, r_cnt;
  always_comb begin
    w_n1d = '0;
    for (int i = 0; i < 8; i++) w_n1d = w_n1d + 4'(bus.data_i[i]);
    w_xnor = (w_n1d > 4'd4) || (w_n1d == 4'd4 && !bus.data_i[0]);
    w_qm = '0;
    w_qm[0] = bus.data_i[0];
    for (int i = 1; i < 8; i++) w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ bus.data_i[i]) : (w_qm[i-1] ^ bus.data_i[i]);
    w_qm[8] = ~w_xnor;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_qm   <= '0;
      r_de   <= 1'b0;
      r_ctrl <= 2'b00;
    end else begin
      r_qm   <= w_qm;
      r_de   <= bus.de_i;
      r_ctrl <= bus.ctrl_i;
    end
  end
  // w_d is n1-n0 of q_m[7:0], i.e. 2*n1-8
  always_comb begin
    w_n1 = '0;
    for (int i = 0; i < 8; i++) w_n1 = w_n1 + 4'(r_qm[i]);
    w_d = CNT_W'({1'b0, w_n1, 1'b0}) - CNT_W'(8);
    w_ctl = r_ctrl == 2'b00 ? 10'b1101010100 :
            r_ctrl == 2'b01 ? 10'b0010101011 :
            r_ctrl == 2'b10 ? 10'b0101010100 : 10'b1010101011;
    w_tmds = w_ctl;
    w_cnt_nx = '0;
    if (r_de) begin
      if (r_cnt == 0 || w_d == 0) begin
        w_tmds   = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
        w_cnt_nx = r_cnt + (r_qm[8] ? w_d : -w_d);
      end else if ((r_cnt > 0 && w_d > 0) || (r_cnt < 0 && w_d < 0)) begin
        w_tmds   = {1'b1, r_qm[8], ~r_qm[7:0]};
        w_cnt_nx = r_cnt + (r_qm[8] ? CNT_W'(2) : '0) - w_d;
      end else begin
        w_tmds   = {1'b0, r_qm[8], r_qm[7:0]};
        w_cnt_nx = r_cnt + w_d - (r_qm[8] ? '0 : CNT_W'(2));
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_tmds <= 10'b1101010100;
      r_cnt  <= '0;
    end else begin
      r_tmds <= w_tmds;
      r_cnt  <= w_cnt_nx;
    end
  end
  assign bus.tmds_o = r_tmds;
  assign bus.disp_o = r_cnt;
endmodule
